// File: rtl/div_unit_pkg.sv
// Shared types and constants for the execute-stage divider.
// Latency: n/a (declarations only).
// Backpressure: n/a; the stall encodings used toward the stall control unit live here.
//
// Contents: state encodings, start/stop and stall encodings, the double-width
// result bus type, and a conditional two's-complement negation helper.
package div_unit_pkg;

    localparam int REG_W        = 32;
    localparam int DOUBLE_REG_W = 64;

    typedef logic [DOUBLE_REG_W-1:0] double_reg_bus_t;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    // Two's-complement negation when neg is set. 0x80000000 maps to itself,
    // which is exactly the wrap-around behaviour wanted for MIN_INT / -1.
    function automatic logic [REG_W-1:0] negate_if(input logic [REG_W-1:0] v,
                                                   input logic             neg);
        return neg ? (~v + {{(REG_W-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the partial remainder left, trial-subtract the divisor.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle, the caller decides when to register the result.
//
// Ports:
//   rem_in   - 33-bit partial remainder before this step
//   divisor  - 32-bit divisor magnitude
//   bit_in   - next dividend bit shifted into the remainder LSB
//   rem_out  - partial remainder after this step
//   quo_bit  - quotient bit produced by this step
module div_step
    import div_unit_pkg::*;
(
    input  logic [REG_W:0]   rem_in,
    input  logic [REG_W-1:0] divisor,
    input  logic             bit_in,
    output logic [REG_W:0]   rem_out,
    output logic             quo_bit
);

    logic [REG_W+1:0] shifted;
    logic [REG_W+1:0] diff;

    // The 33-bit subtract is carried one bit further so its borrow is
    // unambiguous even when the shifted remainder has bit 32 set.
    assign shifted = {rem_in, bit_in};
    assign diff    = shifted - {2'b00, divisor};

    assign quo_bit = ~diff[REG_W+1];
    assign rem_out = quo_bit ? diff[REG_W:0] : shifted[REG_W:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned 32-bit divider (DIV/DIVU), one quotient bit per clock.
// Latency: 34 cycles start-to-advance for a normal divide (33 edges to div_ready), 3 for divide by zero.
// Backpressure: holds stallreq_exe = STOP while div_start is high and the result is not yet ready.
//
// Ports:
//   cpu_clk_50M, cpu_rst_n    - pipeline clock, async active-low reset
//   div_start, div_signed     - start request (held by the stall), 1 = DIV, 0 = DIVU
//   div_opdata1, div_opdata2  - dividend / divisor, sampled only on the start edge
//   div_annul                 - flush: abort an in-flight divide, suppress a start
//   div_result                - {remainder, quotient}, valid while div_ready = 1
//   div_ready                 - single-cycle result pulse
//   stallreq_exe              - stall request toward the stall control unit
module div_unit
    import div_unit_pkg::*;
(
    input  logic                    cpu_clk_50M,
    input  logic                    cpu_rst_n,
    input  logic                    div_start,
    input  logic                    div_signed,
    input  logic [REG_W-1:0]        div_opdata1,
    input  logic [REG_W-1:0]        div_opdata2,
    input  logic                    div_annul,
    output logic [DOUBLE_REG_W-1:0] div_result,
    output logic                    div_ready,
    output logic                    stallreq_exe
);

    div_state_t      state_q;
    div_state_t      state_d;
    logic [5:0]      cnt_q;
    logic [REG_W:0]  rem_q;
    logic [REG_W-1:0] quo_q;
    logic [REG_W-1:0] dvsr_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    double_reg_bus_t result_q;

    logic [REG_W:0]  step_rem;
    logic            step_bit;
    logic            start_ok;
    logic            by_zero;
    logic            op1_neg;
    logic            op2_neg;
    double_reg_bus_t fixed_result;

    assign start_ok = (div_start == DIV_START) && !div_annul;
    assign by_zero  = (div_opdata2 == '0);
    assign op1_neg  = div_signed && div_opdata1[REG_W-1];
    assign op2_neg  = div_signed && div_opdata2[REG_W-1];

    // The dividend magnitude lives in quo_q and is consumed MSB-first as the
    // quotient bits fill in from the LSB.
    div_step u_step (
        .rem_in  (rem_q),
        .divisor (dvsr_q),
        .bit_in  (quo_q[REG_W-1]),
        .rem_out (step_rem),
        .quo_bit (step_bit)
    );

    // Remainder follows the dividend's sign; quotient is negated when the
    // operand signs differ.
    assign fixed_result = {negate_if(rem_q[REG_W-1:0], neg_rem_q),
                           negate_if(quo_q, neg_quo_q)};

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q <= DIV_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_FREE: begin
                if (start_ok) begin
                    state_d = by_zero ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: begin
                state_d = div_annul ? DIV_FREE : DIV_END;
            end
            DIV_ON: begin
                if (div_annul) begin
                    state_d = DIV_FREE;
                end else if (cnt_q == 6'd31) begin
                    state_d = DIV_END;
                end
            end
            DIV_END: begin
                state_d = DIV_FREE;
            end
            default: begin
                state_d = DIV_FREE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state_q)
                DIV_FREE: begin
                    if (start_ok) begin
                        cnt_q <= '0;
                        rem_q <= '0;
                        if (by_zero) begin
                            // Zeroed operands make the END sign-fix yield 64'h0.
                            quo_q     <= '0;
                            dvsr_q    <= '0;
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                        end else begin
                            quo_q     <= negate_if(div_opdata1, op1_neg);
                            dvsr_q    <= negate_if(div_opdata2, op2_neg);
                            neg_quo_q <= op1_neg ^ op2_neg;
                            neg_rem_q <= op1_neg;
                        end
                    end
                end
                DIV_ON: begin
                    if (!div_annul) begin
                        rem_q <= step_rem;
                        quo_q <= {quo_q[REG_W-2:0], step_bit};
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                DIV_END: begin
                    result_q <= fixed_result;
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    // In END the fresh result is shown directly; elsewhere the last one is held.
    assign div_ready    = (state_q == DIV_END);
    assign div_result   = div_ready ? fixed_result : result_q;
    assign stallreq_exe = (div_start && !div_ready) ? STOP : NOSTOP;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: table of divides plus annul, reset and back-to-back sequences.
// Latency: checks the 34-cycle (normal) and 3-cycle (divide-by-zero) stall windows.
// Backpressure: div_start is held until div_ready, as the stall control unit would.
module tb_div_unit;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst_n   = 1'b0;
    logic        div_start   = 1'b0;
    logic        div_signed  = 1'b0;
    logic [31:0] div_opdata1 = '0;
    logic [31:0] div_opdata2 = '0;
    logic        div_annul   = 1'b0;
    logic [63:0] div_result;
    logic        div_ready;
    logic        stallreq_exe;

    int total   = 0;
    int bad     = 0;
    int cyc_cnt = 0;

    div_unit dut (
        .cpu_clk_50M  (cpu_clk_50M),
        .cpu_rst_n    (cpu_rst_n),
        .div_start    (div_start),
        .div_signed   (div_signed),
        .div_opdata1  (div_opdata1),
        .div_opdata2  (div_opdata2),
        .div_annul    (div_annul),
        .div_result   (div_result),
        .div_ready    (div_ready),
        .stallreq_exe (stallreq_exe)
    );

    always #5 cpu_clk_50M = ~cpu_clk_50M;
    always @(posedge cpu_clk_50M) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] exp;
        int          held;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Presents a divide (called just after a rising edge) and holds div_start
    // until div_ready. Operands are scrambled after the start edge. Returns the
    // sampled result, the number of cycles from presentation through the
    // div_ready cycle, and the cycle stamp of the div_ready pulse.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input string name,
                          output logic [63:0] res, output int held, output int rdy_at);
        int stall_bad = 0;
        int seen      = 0;
        div_opdata1 = a;
        div_opdata2 = b;
        div_signed  = sgn;
        div_start   = 1'b1;
        held   = 0;
        res    = '0;
        rdy_at = -1;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            @(negedge cpu_clk_50M);
            held++;
            if (div_ready) begin
                seen   = 1;
                res    = div_result;
                rdy_at = cyc_cnt;
                if (stallreq_exe) stall_bad++;
            end else begin
                if (!stallreq_exe) stall_bad++;
                if (held == 2) begin
                    div_opdata1 = ~a;
                    div_opdata2 = b + 32'd5;
                end
            end
        end
        check_int({name, "_ready_seen"}, seen, 1);
        check_int({name, "_stall_shape"}, stall_bad, 0);
        @(posedge cpu_clk_50M);
        #1;
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] prev;
        logic [63:0] r1;
        int          held;
        int          t1;
        int          t2;

        vecs[0]  = '{32'd100,      32'd7,          1'b0, {32'd2,        32'd14},       34};
        vecs[1]  = '{32'hFFFFFF9C, 32'd7,          1'b1, {32'hFFFFFFFE, 32'hFFFFFFF2}, 34};
        vecs[2]  = '{32'd100,      32'hFFFFFFF9,   1'b1, {32'd2,        32'hFFFFFFF2}, 34};
        vecs[3]  = '{32'hFFFFFF9C, 32'hFFFFFFF9,   1'b1, {32'hFFFFFFFE, 32'd14},       34};
        vecs[4]  = '{32'h80000000, 32'hFFFFFFFF,   1'b1, {32'd0,        32'h80000000}, 34};
        vecs[5]  = '{32'hFFFFFFFF, 32'd1,          1'b0, {32'd0,        32'hFFFFFFFF}, 34};
        vecs[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFE,   1'b0, {32'd1,        32'd1},        34};
        vecs[7]  = '{32'd7,        32'd0,          1'b0, 64'h0,                        3};
        vecs[8]  = '{32'h80000000, 32'd0,          1'b1, 64'h0,                        3};
        vecs[9]  = '{32'd5,        32'd9,          1'b0, {32'd5,        32'd0},        34};
        vecs[10] = '{32'hFFFFFF9C, 32'd7,          1'b0, {32'd2,        32'h24924916}, 34};
        vecs[11] = '{32'd7,        32'hFFFFFFFE,   1'b1, {32'd1,        32'hFFFFFFFD}, 34};
        vecs[12] = '{32'hFFFFFFF9, 32'd2,          1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34};

        // Reset state
        #12;
        check_int("rst_ready", int'(div_ready), 0);
        check64("rst_result", div_result, 64'h0);
        check_int("rst_stall", int'(stallreq_exe), 0);
        @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b1;
        @(posedge cpu_clk_50M);
        #1;

        // Table of divides, issued back to back
        for (int i = 0; i < NV; i++) begin
            do_div(vecs[i].a, vecs[i].b, vecs[i].sgn, $sformatf("vec%0d", i), res, held, t1);
            check64($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check_int($sformatf("vec%0d_cycles", i), held, vecs[i].held);
        end
        prev = vecs[NV-1].exp;

        // Annul in ON at T10; start stays high with annul in FREE (suppressed)
        div_opdata1 = 32'd1000;
        div_opdata2 = 32'd3;
        div_signed  = 1'b0;
        div_start   = 1'b1;
        repeat (10) @(posedge cpu_clk_50M);
        #1;
        div_annul = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge cpu_clk_50M);
            check_int($sformatf("annul_ready_%0d", k), int'(div_ready), 0);
            check64($sformatf("annul_result_%0d", k), div_result, prev);
        end
        @(posedge cpu_clk_50M);
        #1;
        div_annul = 1'b0;
        do_div(32'd9, 32'd3, 1'b0, "after_annul", res, held, t1);
        check64("after_annul_result", res, {32'd0, 32'd3});
        check_int("after_annul_cycles", held, 34);

        // Reset mid-ON at T20
        div_opdata1 = 32'd1000;
        div_opdata2 = 32'd7;
        div_signed  = 1'b0;
        repeat (20) @(posedge cpu_clk_50M);
        #2;
        check64("pre_rst_result", div_result, {32'd0, 32'd3});
        cpu_rst_n = 1'b0;
        div_start = 1'b0;
        #1;
        check_int("midrst_ready", int'(div_ready), 0);
        check64("midrst_result", div_result, 64'h0);
        check_int("midrst_stall", int'(stallreq_exe), 0);
        repeat (2) @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b1;
        @(posedge cpu_clk_50M);
        #1;
        check_int("postrst_ready", int'(div_ready), 0);

        // Back-to-back after reset: exactly one FREE cycle between pulses
        do_div(32'd50, 32'd5, 1'b0, "b2b_a", r1, held, t1);
        check64("b2b_a_result", r1, {32'd0, 32'd10});
        check_int("b2b_a_cycles", held, 34);
        do_div(32'd7, 32'd2, 1'b0, "b2b_b", res, held, t2);
        check64("b2b_b_result", res, {32'd1, 32'd3});
        check_int("b2b_b_cycles", held, 34);
        check_int("b2b_spacing", t2 - t1, 34);

        div_start = 1'b0;
        @(negedge cpu_clk_50M);
        check_int("idle_stall", int'(stallreq_exe), 0);
        check_int("idle_ready", int'(div_ready), 0);
        check64("idle_result_held", div_result, {32'd1, 32'd3});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit divider for the execute stage of the MiniMIPS32 pipeline, serving DIV and DIVU. It iterates one quotient bit per clock and raises `stallreq_exe` toward the stall control unit until the 64-bit {remainder, quotient} result is ready. The EXE stage then writes the result to HI/LO. It is the sole producer of `stallreq_exe`.

## Interface
Parameters: none. Widths come from the shared defines.

Ports:
- `cpu_clk_50M`  in  1  pipeline clock
- `cpu_rst_n`  in  1  asynchronous, active-low reset
- `div_start`  in  1  EXE holds a DIV/DIVU. Held high by the stall until `div_ready`.
- `div_signed`  in  1  1 = DIV (two's complement), 0 = DIVU
- `div_opdata1`  in  32  dividend (rs)
- `div_opdata2`  in  32  divisor (rt)
- `div_annul`  in  1  abort the in-flight division (flush)
- `div_result`  out  64  {remainder[63:32] → HI, quotient[31:0] → LO}
- `div_ready`  out  1  result valid, single-cycle pulse
- `stallreq_exe`  out  1  stall request to the stall control unit (`STOP` = 1)

## Operation
- Reset is asynchronous and active-low:
  - state = FREE, cnt = 0
  - `div_result` = 64'h0, `div_ready` = 0
- `stallreq_exe` = `div_start` & ~`div_ready`. Combinational, so the stall is raised in the same cycle the DIV enters EXE.
- FSM states: FREE, BY_ZERO, ON, END.
  - FREE: on `div_start` & ~`div_annul`:
    - if divisor == 0, go to BY_ZERO;
    - otherwise latch |dividend| and |divisor|, clear the partial remainder, set cnt = 0, go to ON.
    - Magnitudes are two's-complement negations only when `div_signed` is set and the operand's bit 31 is 1.
  - BY_ZERO: go to END with result forced to 64'h0.
  - ON: one restoring step per cycle.
    - Shift {rem, quo} left by 1 and form diff = rem[32:0] − {1'b0, divisor}.
    - If diff is non-negative, rem = diff and shift in a 1; otherwise shift in a 0.
    - cnt increments each step. After step 32 (cnt = 31 → 32), go to END.
  - END:
    - Sign-fix the result: quotient is negated if signed and the operand signs differ; remainder takes the dividend's sign.
    - Drive `div_result` and `div_ready` = 1 for this one cycle, then go to FREE unconditionally.
- `div_annul` in ON or BY_ZERO: return to FREE next cycle. `div_ready` stays 0 and `div_result` keeps its previous value.
- `div_annul` in FREE suppresses a start.
- Width rules:
  - partial remainder is 33 bits internally, with a 33-bit subtract;
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0 (wraps, no trap);
  - divide by zero gives all-zero result, no exception.
- `div_result` holds its last value outside END. Consumers sample it only while `div_ready` = 1.

## Timing
- T0 = first edge with `div_start` = 1 in FREE. `stallreq_exe` is already 1 during the cycle before that edge.
- Normal divide:
  - ON for T1..T32;
  - END at T33: `div_ready` = 1, `stallreq_exe` = 0;
  - pipeline advances on the T33→T34 edge.
  - The stall lasts 34 cycles in total.
- Divide by zero: BY_ZERO at T1, END at T2, stall lasts 3 cycles.
- Back-to-back DIVs: END → FREE, then the next `div_start` is accepted on the following edge. There is one FREE cycle between results.
- Reset mid-ON: immediate return to FREE, outputs cleared, no `div_ready`.
- `div_opdata*` are sampled only on the start edge. Later changes are ignored.

## Structure
- Shared defines file adds:
  - `DIV_FREE`, `DIV_BY_ZERO`, `DIV_ON`, `DIV_END` (2-bit state encodings)
  - `DIV_START` / `DIV_STOP`
  - `DOUBLE_REG_BUS` (63:0)
  - `STOP` / `NOSTOP` are reused.
- One combinational sub-module, `div_step`: inputs 33-bit rem, 32-bit divisor, incoming bit; outputs next rem and quotient bit. This keeps the FSM file to state, counter and sign handling.
- The FSM and datapath registers live in `div_unit`. No memories.

## Test plan
- DIVU 100 / 7 → after 34 stall cycles, `div_ready` pulse, `div_result` = {32'd2, 32'd14}; `stallreq_exe` falls in the `div_ready` cycle.
- DIV −100 / 7 (0xFFFFFF9C, 7) → {0xFFFFFFFE, 0xFFFFFFF2}. DIV 100 / −7 → {32'd2, 0xFFFFFFF2}.
- DIV 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}, no hang. DIVU 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- Any / 0 → `div_ready` at T2, result 64'h0, stall 3 cycles.
- `div_annul` at T10 → FREE at T11, no `div_ready`, `div_result` unchanged. Then start 9 / 3 → {0, 3} after a full 34-cycle stall.
- `cpu_rst_n` pulled low at T20 → all outputs 0 asynchronously. After release, two back-to-back DIVUs (50/5, 7/2) → {0, 10} then {1, 3}, with exactly one FREE cycle between `div_ready` pulses.
